// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state type for the SPI register responder
package spi_pkg;
  localparam int WORD_LEN   = 8;
  localparam int CMD_WR_BIT = 7;
  localparam int ADDR_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA
  } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchronizer with optional rise/fall pulses
module spi_sync_edge #(
  parameter logic p_RST_VAL = 1'b0,
  parameter bit   p_EDGES   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= p_RST_VAL;
      r_s2 <= p_RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

  generate
    if (p_EDGES) begin : g_edge
      logic r_s3;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_s3 <= p_RST_VAL;
        else       r_s3 <= r_s2;
      end
      assign o_rise = r_s2 & ~r_s3;
      assign o_fall = ~r_s2 & r_s3;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode-0 responder giving burst read/write access to a register bank
module spi_reg_slave
  import spi_pkg::*;
#(
  parameter int         p_WORD_LEN = WORD_LEN,
  parameter int         p_NUM_REGS = 16,
  parameter logic [7:0] p_CMD_ECHO = 8'hA5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_sclk,
  input  logic                    i_mosi,
  input  logic                    i_ss,
  output logic                    o_miso,
  output logic [p_NUM_REGS*8-1:0] o_regs,
  output logic                    o_wr_en,
  output logic [ADDR_W-1:0]       o_wr_addr,
  output logic [7:0]              o_wr_data,
  output logic                    o_busy
);
  localparam int              CNT_W = $clog2(p_WORD_LEN);
  localparam int              IDX_W = (p_NUM_REGS > 1) ? $clog2(p_NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NUM   = p_NUM_REGS[ADDR_W:0];

  logic w_sclk_rise, w_sclk_fall, w_ss, w_mosi;
  logic w_unused_sclk_q, w_unused_ss_rise, w_unused_ss_fall, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync_edge #(.p_RST_VAL(1'b0), .p_EDGES(1'b1)) u_sync_sclk (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk),
    .o_q(w_unused_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.p_RST_VAL(1'b1), .p_EDGES(1'b0)) u_sync_ss (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_ss),
    .o_q(w_ss), .o_rise(w_unused_ss_rise), .o_fall(w_unused_ss_fall)
  );
  spi_sync_edge #(.p_RST_VAL(1'b0), .p_EDGES(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi),
    .o_q(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [7:0]        r_rx;
  logic [7:0]        r_tx;
  logic              r_miso;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_regs [p_NUM_REGS];

  logic              w_byte_done;
  logic [7:0]        w_rx_byte;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [7:0]        w_rd_data;
  logic              w_addr_ok;

  assign w_byte_done = w_sclk_rise && (r_bit_cnt == CNT_W'(p_WORD_LEN - 1));
  assign w_rx_byte   = {r_rx[6:0], w_mosi};
  // While the command byte completes, the start address is still in the shifter.
  assign w_rd_addr   = (r_state == ST_CMD) ? w_rx_byte[ADDR_W-1:0] : r_addr;
  assign w_addr_ok   = ({1'b0, r_addr} < NUM);

  always_comb begin
    w_rd_data = 8'h00;
    if ({1'b0, w_rd_addr} < NUM) w_rd_data = r_regs[w_rd_addr[IDX_W-1:0]];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_miso    <= 1'b0;
      r_addr    <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      for (int n = 0; n < p_NUM_REGS; n++) r_regs[n] <= 8'h00;
    end else begin
      o_wr_en <= 1'b0;
      if (w_ss) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_rx      <= '0;
        r_tx      <= '0;
        r_miso    <= 1'b0;
      end else begin
        if (w_sclk_rise) begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          r_rx      <= w_rx_byte;
        end
        if (w_sclk_fall) begin
          r_miso <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_CMD;
            r_miso  <= p_CMD_ECHO[7];
            r_tx    <= {p_CMD_ECHO[6:0], 1'b0};
          end
          ST_CMD: begin
            if (w_byte_done) begin
              if (w_rx_byte[CMD_WR_BIT]) begin
                r_state <= ST_WDATA;
                r_addr  <= w_rx_byte[ADDR_W-1:0];
                r_tx    <= 8'h00;
              end else begin
                r_state <= ST_RDATA;
                r_addr  <= w_rx_byte[ADDR_W-1:0] + ADDR_W'(1);
                r_tx    <= w_rd_data;
              end
            end
          end
          ST_RDATA: begin
            if (w_byte_done) begin
              r_tx   <= w_rd_data;
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
          ST_WDATA: begin
            if (w_byte_done) begin
              if (w_addr_ok) begin
                r_regs[r_addr[IDX_W-1:0]] <= w_rx_byte;
                o_wr_en   <= 1'b1;
                o_wr_addr <= r_addr;
                o_wr_data <= w_rx_byte;
              end
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    o_regs = '0;
    for (int n = 0; n < p_NUM_REGS; n++) o_regs[8*n +: 8] = r_regs[n];
  end

  assign o_busy = ~w_ss;
  assign o_miso = i_ss ? 1'bz : r_miso;
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - randomized bench for spi_reg_slave, two devices on one MISO wire
module tb_spi_reg_slave;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic ss0 = 1'b1;
  logic ss1 = 1'b1;
  wire  miso;
  pullup (miso);

  logic [NREG*8-1:0] regs0, regs1;
  logic              wr0, wr1, busy0, busy1;
  logic [6:0]        wa0, wa1;
  logic [7:0]        wd0, wd1;

  always #5 clk = ~clk;

  spi_reg_slave #(.p_NUM_REGS(NREG)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_mosi(mosi), .i_ss(ss0),
    .o_miso(miso), .o_regs(regs0), .o_wr_en(wr0), .o_wr_addr(wa0),
    .o_wr_data(wd0), .o_busy(busy0)
  );
  spi_reg_slave #(.p_NUM_REGS(NREG)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_mosi(mosi), .i_ss(ss1),
    .o_miso(miso), .o_regs(regs1), .o_wr_en(wr1), .o_wr_addr(wa1),
    .o_wr_data(wd1), .o_busy(busy1)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          hp = 5;
  logic [7:0]  mdl [2][128];
  logic [7:0]  tx_q[$];
  logic [15:0] wr_seen[$];
  logic [15:0] exp_wr[$];

  always @(negedge clk) begin
    if (wr0) wr_seen.push_back({1'b0, wa0, wd0});
    if (wr1) wr_seen.push_back({1'b1, wa1, wd1});
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NREG*8-1:0] pack(input int dev);
    logic [NREG*8-1:0] r;
    for (int n = 0; n < NREG; n++) r[8*n +: 8] = mdl[dev][n];
    return r;
  endfunction

  task automatic xfer_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(hp);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      wait_clk(hp);
      sclk = 1'b0;
    end
  endtask

  task automatic compare_state(input string tag);
    check_eq({tag, "_wr_count"}, wr_seen.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < wr_seen.size(); k++)
      check_eq({tag, "_wr_entry"}, wr_seen[k], exp_wr[k]);
    wr_seen.delete();
    exp_wr.delete();
    check_eq({tag, "_regs0"}, regs0, pack(0));
    check_eq({tag, "_regs1"}, regs1, pack(1));
  endtask

  // One transaction to device dev; tx_q holds data bytes, the last one sent with last_bits bits.
  task automatic txn(input int dev, input logic [7:0] cmd, input int last_bits);
    logic [6:0] a;
    logic [7:0] rx, exp;
    int         nb;
    a = cmd[6:0];
    if (dev == 0) ss0 = 1'b0; else ss1 = 1'b0;
    wait_clk(6);
    check_eq("busy_on", (dev == 0) ? busy0 : busy1, 1'b1);
    xfer_byte(cmd, 8, rx);
    check_eq("echo", rx, 8'hA5);
    for (int k = 0; k < tx_q.size(); k++) begin
      nb  = (k == tx_q.size() - 1) ? last_bits : 8;
      exp = (cmd[7] || int'(a) >= NREG) ? 8'h00 : mdl[dev][a];
      xfer_byte(tx_q[k], nb, rx);
      if (nb == 8) begin
        check_eq("miso_byte", rx, exp);
        check_eq("miso_known", $isunknown(miso), 1'b0);
        if (cmd[7] && int'(a) < NREG) begin
          mdl[dev][a] = tx_q[k];
          exp_wr.push_back({dev[0], a, tx_q[k]});
        end
      end
      a = a + 7'd1;
    end
    wait_clk(hp);
    ss0 = 1'b1;
    ss1 = 1'b1;
    wait_clk(8);
    check_eq("busy_off", (dev == 0) ? busy0 : busy1, 1'b0);
    check_eq("miso_idle", miso, 1'b1);
    compare_state("txn");
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] cmd;
    int         dev, len, lb;
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 128; n++) mdl[d][n] = 8'h00;

    wait_clk(3);
    check_eq("rst_miso_z", miso, 1'b1);
    rst = 1'b0;
    wait_clk(5);
    check_eq("idle_regs0", regs0, '0);
    check_eq("idle_busy0", busy0, 1'b0);
    check_eq("idle_miso_z", miso, 1'b1);
    compare_state("idle");

    tx_q = '{8'h11, 8'h22};
    txn(0, 8'h82, 8);
    check_eq("reg2", regs0[23:16], 8'h11);
    check_eq("reg3", regs0[31:24], 8'h22);
    tx_q = '{8'h00, 8'h00};
    txn(0, 8'h02, 8);

    tx_q = '{8'h33, 8'h44};
    txn(0, 8'hFF, 8);
    check_eq("wrap_reg0", regs0[7:0], 8'h44);
    tx_q = '{8'h00, 8'h00};
    txn(0, 8'h14, 8);

    tx_q = '{8'h5A};
    txn(0, 8'h81, 5);
    tx_q = '{8'h00};
    txn(0, 8'h01, 8);

    hp = 10;
    tx_q = '{8'hDE, 8'hAD, 8'hBE};
    txn(1, 8'h80, 8);
    tx_q = '{8'h00, 8'h00, 8'h00};
    txn(1, 8'h00, 8);
    tx_q = '{8'h00};
    txn(0, 8'h00, 8);
    hp = 5;

    for (int t = 0; t < 30; t++) begin
      dev = ($urandom_range(0, 4) == 0) ? 1 : 0;
      hp  = (dev == 1) ? 10 : 5;
      cmd[7]   = $urandom_range(0, 1);
      cmd[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 19));
      len = $urandom_range(1, 4);
      lb  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
      tx_q.delete();
      for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
      txn(dev, cmd, lb);
    end
    hp = 5;

    ss0 = 1'b0;
    wait_clk(6);
    xfer_byte(8'h83, 8, rx);
    xfer_byte(8'h5C, 4, rx);
    rst = 1'b1;
    wait_clk(2);
    check_eq("midrst_regs0", regs0, '0);
    check_eq("midrst_busy", busy0, 1'b0);
    check_eq("midrst_wr_en", wr0, 1'b0);
    ss0 = 1'b1;
    sclk = 1'b0;
    wait_clk(1);
    check_eq("midrst_miso_z", miso, 1'b1);
    rst = 1'b0;
    wait_clk(8);
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 128; n++) mdl[d][n] = 8'h00;
    compare_state("midrst");

    tx_q = '{8'h77};
    txn(0, 8'h85, 8);
    tx_q = '{8'h00};
    txn(0, 8'h05, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
SPI responder that gives an SPI initiator (spi_master) read/write access to a bank of 8-bit control registers. It oversamples SCLK, MOSI and SS in the system clock domain and decodes a command byte followed by a burst of data bytes with address auto-increment. It sits beside spi_slave on the shared SCLK/MOSI/MISO bus and has its own slave select.

Parameters:
p_WORD_LEN, 8, bits per SPI word; fixed at 8 for this block.
p_NUM_REGS, 16, number of implemented registers (1..128).
p_CMD_ECHO, 8'hA5, byte shifted out on MISO during the command byte.

Ports:
i_clk  input  1  system clock; SPI signals are oversampled on its rising edge
i_rst  input  1  asynchronous active-high reset
i_sclk  input  1  SPI clock, mode 0 (idle low)
i_mosi  input  1  SPI data in, MSB first
i_ss  input  1  slave select, active low
o_miso  output  1  SPI data out, MSB first; high-Z whenever i_ss is high (combinational on raw i_ss)
o_regs  output  p_NUM_REGS*8  flattened register bank; reg n is bits [8n+7:8n]
o_wr_en  output  1  one-cycle pulse when a register is written
o_wr_addr  output  7  address of the write
o_wr_data  output  8  data of the write
o_busy  output  1  high while synchronized SS is low

Behaviour:
- Reset: all registers 0x00; o_wr_en 0; o_wr_addr 0; o_wr_data 0; o_busy 0; state IDLE; shift registers cleared; MISO drive register 0.
- Sync: i_sclk, i_mosi and i_ss each pass through 2 flops. SCLK rise/fall are detected from the 2nd and 3rd flop stages. Required SCLK high and low times: >= 4 i_clk periods each.
- Mode 0: sample MOSI on SCLK rise; update the MISO drive bit on SCLK fall. The first MSB is driven on the cycle after SS falls.
- Bit counter: 3 bits; a byte completes on the 8th rise; the counter resets whenever SS is high.
- Command byte: bit7 = 1 means write, 0 means read; bits[6:0] are the start address.
- States:
  IDLE: leave on SS low -> CMD.
  CMD: shift out p_CMD_ECHO. On byte complete, load addr, then go to WDATA if write, else RDATA.
  RDATA: on entry and after each byte, load the tx shift register with reg[addr]. A byte completes on the 8th rise. The MSB is driven on the following SCLK fall. Then addr increments.
  WDATA: on byte complete, write reg[addr], pulse o_wr_en for exactly 1 cycle (o_wr_addr and o_wr_data valid in that cycle), then addr increments. MISO drives 0x00.
  Any state: synchronized SS high -> IDLE, and the partial byte is discarded (no write).
- Address: 7-bit counter that wraps 127 -> 0. Addresses >= p_NUM_REGS are ignored on write (no o_wr_en pulse) and read back as 0x00. The counter still increments past them.
- A register updated in the same cycle it is loaded for read returns the old value.
- A write takes effect in o_regs on the cycle after byte completion, aligned with o_wr_en.
- SS re-asserted without an idle gap: a new transaction starts in CMD.
- Reset mid-transaction: immediate return to reset state; o_miso stays high-Z if SS is high.

Decomposition:
- Shared package spi_pkg:
  - word-length constant 8
  - command write-bit index 7
  - state enum IDLE/CMD/WDATA/RDATA
  - address width 7
- Sub-module spi_sync_edge: 2-flop synchronizer with rise/fall pulse outputs. Used for SCLK; the same module without edge outputs is used for SS and MOSI.

Test Plan:
- Reset then idle, SS high -> o_miso = z, o_regs all 0x00, o_busy = 0, no o_wr_en.
- Write burst: SS low, send 0x82, 0x11, 0x22 -> reg2 = 0x11 and reg3 = 0x22; two o_wr_en pulses with addr 2/3; MISO bytes 0xA5, 0x00, 0x00.
- Read burst after that write: send 0x02, 0x00, 0x00 -> master receives 0xA5, 0x11, 0x22.
- Out of range and wrap, p_NUM_REGS = 16: write 0xFF (addr 127) then data 0x33, 0x44 -> no pulse for addr 127; reg0 = 0x44. Reading addr 20 returns 0x00.
- Abort: send 0x81 then 5 bits of data, raise SS -> no o_wr_en, reg1 unchanged. Next transaction (read 0x01) returns the old value.
- Shared bus: two instances on one MISO wire, only one SS low -> no X on MISO; the selected device's data is received, with SCLK half-period 10 i_clk.
